cache_mem_arbiter: RTL and testbench

Shares one cacheline-wide physical memory port between the instruction-side and data-side caches feeding the pipelined datapath's `instr_mem_*` and `data_mem_*` ports. Accepts at most one outstanding line transaction at a time and grants round-robin on contention, so neither fetch nor the MEM stage can starve. Latches the winning request, drives memory until `mem_resp`, then returns registered read data and a one-cycle response pulse to the winner.

---
 rtl/cache_mem_arbiter_pkg.sv | 26 ++
 rtl/cache_mem_arbiter_grant_sel.sv | 24 ++
 rtl/cache_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D cache memory-port arbiter: FSM states, grant
// identity and the line-offset width derived from the cacheline size.
package arb_types;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP
   } arb_state_t;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } arb_grant_t;

   localparam int LINE_W_DEFAULT = 256;

   // Number of byte-offset bits inside one cacheline.
   function automatic int line_off_w(input int line_w);
      return $clog2(line_w / 8);
   endfunction

   localparam int LINE_OFF_W = line_off_w(LINE_W_DEFAULT);

endpackage

// File: rtl/cache_mem_arbiter_grant_sel.sv
// Round-robin winner selection between the I-side and D-side requesters.
// Purely combinational; the caller owns the last-grant state.
module arb_grant_sel
   import arb_types::*;
(
   input  logic       i_req,
   input  logic       d_req,
   input  arb_grant_t last_grant,
   output arb_grant_t grant,
   output logic       valid
);

   always_comb begin
      valid = i_req | d_req;
      grant = GRANT_I;
      if (i_req && d_req) begin
         // On a tie the side that did not win last time goes next.
         grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
      end else if (d_req) begin
         grant = GRANT_D;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline-wide memory port between the I-cache and D-cache,
// one outstanding transaction at a time, round-robin on contention.
module cache_mem_arbiter
   import arb_types::*;
#(
   parameter int LINE_W = LINE_W_DEFAULT,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   localparam int OFF_W = line_off_w(LINE_W);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

   arb_state_t        state_q, state_d;
   arb_grant_t        last_grant_q, last_grant_d;
   arb_grant_t        grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_resp_q, i_resp_d;
   logic              d_resp_q, d_resp_d;

   arb_grant_t        sel_grant;
   logic              sel_valid;

   arb_grant_sel u_grant_sel (
      .i_req      (i_read),
      .d_req      (d_read | d_write),
      .last_grant (last_grant_q),
      .grant      (sel_grant),
      .valid      (sel_valid)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      i_resp_d     = 1'b0;
      d_resp_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               grant_d      = sel_grant;
               last_grant_d = sel_grant;
               wdata_d      = d_wdata;
               if (sel_grant == GRANT_D) begin
                  // A simultaneous read and writeback from D: the writeback wins.
                  addr_d      = d_addr;
                  mem_write_d = d_write;
                  mem_read_d  = ~d_write;
                  state_d     = BUSY_D;
               end else begin
                  addr_d      = i_addr;
                  mem_write_d = 1'b0;
                  mem_read_d  = 1'b1;
                  state_d     = BUSY_I;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_resp) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (mem_read_q) begin
                  if (grant_q == GRANT_I) i_rdata_d = mem_rdata;
                  else                    d_rdata_d = mem_rdata;
               end
               i_resp_d = (grant_q == GRANT_I);
               d_resp_d = (grant_q == GRANT_D);
               state_d  = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_I;
         grant_q      <= GRANT_I;
         addr_q       <= '0;
         wdata_q      <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_resp_q     <= 1'b0;
         d_resp_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_resp_q     <= i_resp_d;
         d_resp_q     <= d_resp_d;
      end
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = addr_q & ~OFF_MASK;
   assign mem_wdata = wdata_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_resp    = i_resp_q;
   assign d_resp    = d_resp_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a scripted memory responder plus
// hand-computed expectations for grants, commands, data and response pulses.
module tb_cache_mem_arbiter;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;

   always #5 clk = ~clk;

   cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_read    (i_read),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_resp    (i_resp),
      .d_read    (d_read),
      .d_write   (d_write),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_resp    (d_resp),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_resp  (mem_resp)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [LINE_W-1:0] exp_i_rdata = '0;
   logic [LINE_W-1:0] exp_d_rdata = '0;

   task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                           input logic [LINE_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Waits for the command, holds it for lat cycles, answers, and checks the
   // response cycle plus the idle cycle after it. Returns at the idle cycle.
   task automatic txn(input bit side_d, input bit wr, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] wdata, input int lat,
                      input logic [LINE_W-1:0] rdata, input bit churn,
                      output int waited);
      logic [ADDR_W-1:0] exp_addr;
      exp_addr = addr & ~32'h1F;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!(mem_read || mem_write) && waited < 20);
      if (!(mem_read || mem_write)) begin
         check_eq("cmd_seen", LINE_W'(mem_read | mem_write), LINE_W'(1'b1));
         return;
      end
      for (int k = 1; k <= lat; k++) begin
         if (k > 1) @(negedge clk);
         check_eq("mem_read", LINE_W'(mem_read), LINE_W'(!wr));
         check_eq("mem_write", LINE_W'(mem_write), LINE_W'(wr));
         check_eq("mem_addr", LINE_W'(mem_addr), LINE_W'(exp_addr));
         if (wr) check_eq("mem_wdata", mem_wdata, wdata);
         if (churn && k == 1) begin
            d_addr  = ~d_addr;
            d_wdata = ~d_wdata;
            i_addr  = ~i_addr;
         end
         if (k == lat) begin
            mem_resp  = 1'b1;
            mem_rdata = rdata;
         end
      end
      @(negedge clk);
      mem_resp  = 1'b0;
      mem_rdata = ~rdata;
      if (!side_d)  exp_i_rdata = rdata;
      else if (!wr) exp_d_rdata = rdata;
      check_eq("i_resp", LINE_W'(i_resp), LINE_W'(!side_d));
      check_eq("d_resp", LINE_W'(d_resp), LINE_W'(side_d));
      check_eq("i_rdata", i_rdata, exp_i_rdata);
      check_eq("d_rdata", d_rdata, exp_d_rdata);
      check_eq("cmd_drop", LINE_W'(mem_read | mem_write), LINE_W'(1'b0));
      if (side_d) begin
         d_read  = 1'b0;
         d_write = 1'b0;
      end else begin
         i_read = 1'b0;
      end
      @(negedge clk);
      check_eq("resp_pulse", LINE_W'(i_resp | d_resp), LINE_W'(1'b0));
      check_eq("idle_cmd", LINE_W'(mem_read | mem_write), LINE_W'(1'b0));
      $display("txn side=%s %s addr=%h lat=%0d waited=%0d", side_d ? "D" : "I",
               wr ? "WR" : "RD", exp_addr, lat, waited);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [LINE_W-1:0] pat_a, pat_b, pat_c, wd_a5, wd_churn;
      pat_a    = {8{32'h1234_5678}};
      pat_b    = {8{32'hCAFE_F00D}};
      pat_c    = {8{32'h0BAD_BEEF}};
      wd_a5    = {32{8'hA5}};
      wd_churn = {8{32'h3C3C_0F0F}};

      rst = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_mem_read", LINE_W'(mem_read), '0);
      check_eq("rst_mem_write", LINE_W'(mem_write), '0);
      check_eq("rst_mem_addr", LINE_W'(mem_addr), '0);
      check_eq("rst_mem_wdata", mem_wdata, '0);
      check_eq("rst_rdata", i_rdata | d_rdata, '0);
      check_eq("rst_resp", LINE_W'(i_resp | d_resp), '0);
      rst = 1'b1;
      @(negedge clk);

      // Tie straight after reset: D first, then I with no gap grant.
      i_read = 1'b1; i_addr = 32'h0000_1000;
      d_read = 1'b1; d_addr = 32'h0000_2000;
      txn(1'b1, 1'b0, 32'h0000_2000, '0, 2, pat_b, 1'b0, w);
      check_eq("tie_d_wait", LINE_W'(w), LINE_W'(1));
      txn(1'b0, 1'b0, 32'h0000_1000, '0, 2, pat_a, 1'b0, w);
      check_eq("tie_i_wait", LINE_W'(w), LINE_W'(1));

      // I-only with latency 4.
      i_read = 1'b1; i_addr = 32'h0000_0064;
      txn(1'b0, 1'b0, 32'h0000_0064, '0, 4, pat_c, 1'b0, w);
      check_eq("ionly_wait", LINE_W'(w), LINE_W'(1));

      // Round-robin under continuous contention: D, I, D, I.
      i_read = 1'b1; i_addr = 32'h0000_3000;
      d_read = 1'b1; d_addr = 32'h0000_4000;
      txn(1'b1, 1'b0, 32'h0000_4000, '0, 1, pat_a, 1'b0, w);
      d_read = 1'b1;
      txn(1'b0, 1'b0, 32'h0000_3000, '0, 3, pat_b, 1'b0, w);
      check_eq("rr_i1_wait", LINE_W'(w), LINE_W'(1));
      i_read = 1'b1;
      txn(1'b1, 1'b0, 32'h0000_4000, '0, 2, pat_c, 1'b0, w);
      check_eq("rr_d2_wait", LINE_W'(w), LINE_W'(1));
      txn(1'b0, 1'b0, 32'h0000_3000, '0, 1, pat_a, 1'b0, w);
      check_eq("rr_i2_wait", LINE_W'(w), LINE_W'(1));

      // Writeback with a simultaneous D read: write wins, d_rdata untouched.
      d_write = 1'b1; d_read = 1'b1; d_addr = 32'h8000_0040; d_wdata = wd_a5;
      txn(1'b1, 1'b1, 32'h8000_0040, wd_a5, 2, pat_b, 1'b0, w);

      // Input churn during BUSY_D must not reach the memory port.
      d_write = 1'b1; d_addr = 32'h1000_0020; d_wdata = wd_churn;
      txn(1'b1, 1'b1, 32'h1000_0020, wd_churn, 3, pat_c, 1'b1, w);

      // Reset in the middle of BUSY_I, late mem_resp afterwards.
      i_read = 1'b1; i_addr = 32'h0000_0200;
      @(negedge clk);
      check_eq("rb_mem_read", LINE_W'(mem_read), LINE_W'(1'b1));
      @(negedge clk);
      rst = 1'b0; i_read = 1'b0;
      @(negedge clk);
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      check_eq("rb_cmd", LINE_W'(mem_read | mem_write), '0);
      check_eq("rb_mem_addr", LINE_W'(mem_addr), '0);
      check_eq("rb_i_rdata", i_rdata, exp_i_rdata);
      check_eq("rb_d_rdata", d_rdata, exp_d_rdata);
      mem_resp = 1'b1; mem_rdata = pat_a;
      @(negedge clk);
      rst = 1'b1;
      check_eq("rb_resp0", LINE_W'(i_resp | d_resp), '0);
      @(negedge clk);
      mem_resp = 1'b0;
      check_eq("rb_resp1", LINE_W'(i_resp | d_resp), '0);
      check_eq("rb_i_rdata2", i_rdata, exp_i_rdata);
      check_eq("rb_cmd2", LINE_W'(mem_read | mem_write), '0);
      @(negedge clk);
      check_eq("rb_resp2", LINE_W'(i_resp | d_resp), '0);
      d_read = 1'b1; d_addr = 32'h0000_5000;
      txn(1'b1, 1'b0, 32'h0000_5000, '0, 2, pat_b, 1'b0, w);
      check_eq("rb_next_wait", LINE_W'(w), LINE_W'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
